// File: rtl/arb_rr_onehot_sched.sv
// Round-robin scheduler for up to 15 requesters: binary + one-hot grant,
// per-tenure hold limit with preemption, and a one-cycle turnaround gap.

// Per-requester cell: flags requests at or above the rotating pointer.
module arb_rr_onehot_sched_lane #(
  parameter int LANE = 0
) (
  input  logic [3:0] ptr,
  input  logic       req_bit,
  output logic       hi
);
  assign hi = req_bit && (4'(LANE) >= ptr);
endmodule

// 4-bit binary to one-hot, truncated to N outputs.
module arb_rr_onehot_sched_enc #(
  parameter int N = 15
) (
  input  logic [3:0]   bin,
  output logic [N-1:0] oh
);
  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++) oh[i] = (bin == 4'(i));
  end
endmodule

module arb_rr_onehot_sched #(
  parameter int N        = 15,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic         grant_valid,
  output logic [3:0]   grant_idx,
  output logic [N-1:0] grant_oh,
  output logic         timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  typedef struct packed {
    logic         valid;
    logic [3:0]   idx;
    logic [N-1:0] oh;
    logic         timeout;
  } grant_t;

  state_t       state;
  logic [3:0]   ptr;
  logic [7:0]   hold_cnt;
  grant_t       gnt;

  logic [N-1:0] req_hi;
  logic [3:0]   win;
  logic [N-1:0] win_oh;
  logic [3:0]   win_nxt;
  logic         owner_req;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      arb_rr_onehot_sched_lane #(.LANE(g)) u_lane (
        .ptr     (ptr),
        .req_bit (req[g]),
        .hi      (req_hi[g])
      );
    end
  endgenerate

  // Lowest set bit at/above ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i])    win = 4'(i);
    for (int i = N - 1; i >= 0; i--) if (req_hi[i]) win = 4'(i);
  end

  arb_rr_onehot_sched_enc #(.N(N)) u_enc (
    .bin (win),
    .oh  (win_oh)
  );

  assign win_nxt   = (win == 4'(N - 1)) ? 4'd0 : win + 4'd1;
  // Only the owner's own request bit matters during a tenure.
  assign owner_req = |(req & gnt.oh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
    end else begin
      case (state)
        GRANT: begin
          if (done || !owner_req) begin
            state <= GAP;
            gnt   <= '0;
          end else if (hold_cnt == 8'(MAX_HOLD)) begin
            state       <= GAP;
            gnt         <= '0;
            gnt.timeout <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          gnt <= '0;
          if (|req) begin
            state     <= GRANT;
            gnt.valid <= 1'b1;
            gnt.idx   <= win;
            gnt.oh    <= win_oh;
            ptr       <= win_nxt;
            hold_cnt  <= 8'd1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign grant_valid = gnt.valid;
  assign grant_idx   = gnt.idx;
  assign grant_oh    = gnt.oh;
  assign timeout     = gnt.timeout;

endmodule

// File: tb/tb_arb_rr_onehot_sched.sv
// Bench for arb_rr_onehot_sched: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_arb_rr_onehot_sched;
  localparam int N        = 15;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic         grant_valid;
  logic [3:0]   grant_idx;
  logic [N-1:0] grant_oh;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  arb_rr_onehot_sched #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, for how long, where search starts.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_ten;
  bit m_to;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_owner <= 0; m_ptr <= 0; m_ten <= 0; m_to <= 1'b0;
    end else if (m_busy) begin
      if (done || !req[m_owner]) begin
        m_busy <= 1'b0; m_to <= 1'b0;
      end else if (m_ten == MAX_HOLD) begin
        m_busy <= 1'b0; m_to <= 1'b1;
      end else begin
        m_ten <= m_ten + 1;
      end
    end else begin
      m_to <= 1'b0;
      if (req != '0) begin
        m_busy  <= 1'b1;
        m_owner <= rr_pick(req, m_ptr);
        m_ten   <= 1;
        m_ptr   <= (rr_pick(req, m_ptr) + 1) % N;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    int exp_oh;
    exp_oh = m_busy ? (1 << m_owner) : 0;
    chk("model_valid",   int'(grant_valid), int'(m_busy));
    chk("model_idx",     int'(grant_idx),   m_busy ? m_owner : 0);
    chk("model_oh",      int'(grant_oh),    exp_oh);
    chk("model_timeout", int'(timeout),     int'(m_to));
  endtask

  task automatic exp_grant(input string nm, input int idx);
    chk({nm, "_valid"}, int'(grant_valid), 1);
    chk({nm, "_idx"},   int'(grant_idx),   idx);
    chk({nm, "_oh"},    int'(grant_oh),    1 << idx);
    chk({nm, "_to"},    int'(timeout),     0);
  endtask

  task automatic exp_gap(input string nm, input int to);
    chk({nm, "_valid"}, int'(grant_valid), 0);
    chk({nm, "_idx"},   int'(grant_idx),   0);
    chk({nm, "_oh"},    int'(grant_oh),    0);
    chk({nm, "_to"},    int'(timeout),     to);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Asynchronous assert, outputs checked before any clock edge, release at negedge.
  task automatic do_reset();
    req  = '0;
    done = 1'b0;
    rst  = 1'b0;
    #3;
    exp_gap("reset", 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        check_cycle();
      end
    join_none

    // Sole requester, done on third granted cycle, then regrant.
    do_reset();
    req = 15'h0010;
    tick(); exp_grant("t1_c1", 4);
    tick(); exp_grant("t1_c2", 4);
    tick(); exp_grant("t1_c3", 4);
    done = 1'b1;
    tick(); exp_gap("t1_gap", 0);
    done = 1'b0;
    tick(); exp_grant("t1_regrant", 4);

    // All requesting, done every granted cycle: rotation with gaps.
    do_reset();
    req  = 15'h7FFF;
    done = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick(); exp_grant("t2_rot", i % N);
      tick(); exp_gap("t2_gap", 0);
    end

    // Pointer wrap after idx 14.
    do_reset();
    req = 15'h4000;
    tick(); exp_grant("t3_g14", 14);
    req  = 15'h4001;
    done = 1'b1;
    tick(); exp_gap("t3_gap1", 0);
    tick(); exp_grant("t3_g0", 0);
    tick(); exp_gap("t3_gap2", 0);
    tick(); exp_grant("t3_g14b", 14);

    // Hold limit preemption alternating between two requesters.
    do_reset();
    req = 15'h0003;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick(); exp_grant("t4_hold", r % 2);
      end
      if (r < 2) begin
        tick(); exp_gap("t4_timeout", 1);
      end
    end

    // Owner withdraws mid-tenure; done coinciding with the hold limit.
    do_reset();
    req = 15'h0004;
    tick(); exp_grant("t5_c1", 2);
    tick(); exp_grant("t5_c2", 2);
    tick(); exp_grant("t5_c3", 2);
    req = '0;
    tick(); exp_gap("t5_drop", 0);
    tick();
    req = 15'h0004;
    tick(); exp_grant("t5_again", 2);
    repeat (MAX_HOLD - 1) tick();
    exp_grant("t5_at_limit", 2);
    done = 1'b1;
    tick(); exp_gap("t5_done_limit", 0);
    done = 1'b0;

    // Reset mid-grant (idx 5, fourth cycle), then pointer restarts at 0.
    do_reset();
    req = 15'h0020;
    tick(); exp_grant("t6_c1", 5);
    repeat (3) tick();
    exp_grant("t6_c4", 5);
    do_reset();
    req = 15'h0001;
    tick(); exp_grant("t6_ptr0", 0);

    // Randomized traffic; the model is compared on every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      case ($urandom_range(0, 15))
        0:       req = '0;
        1, 2:    req = N'($urandom);
        3, 4, 5: req[$urandom_range(0, N - 1)] ^= 1'b1;
        default: ;
      endcase
      done = ($urandom_range(0, 6) == 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
